// File: rtl/eda_window_fetch.sv
// 3x3 window fetcher: on each accepted center address, reads the in-image
// neighbours from a 1-cycle-latency pixel memory and publishes the window.
module eda_window_fetch #(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M*N)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [ADDR_WIDTH-1:0]               center_addr,
    output logic                                mem_rd_en,
    output logic [ADDR_WIDTH-1:0]               mem_rd_addr,
    input  logic [PIXEL_WIDTH-1:0]              mem_rd_data,
    output logic                                new_pixel,
    output logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    output logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
    output logic [ADDR_WIDTH-1:0]               center_addr_out,
    output logic                                addr_err
);
    localparam int PW = PIXEL_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                          state_q;
    logic [3:0]                      slot_q;
    logic [AW-1:0]                   center_q;
    logic                            err_q;
    logic [WINDOW_WIDTH-1:0]         mask_q;
    logic                            rd_en_q;
    logic [AW-1:0]                   rd_addr_q;
    logic                            pend_q;
    logic [3:0]                      pend_slot_q;
    logic                            pend_in_q;
    logic [PW-1:0]                   pix_q [WINDOW_WIDTH];
    logic [PW*WINDOW_WIDTH-1:0]      win_q;
    logic [WINDOW_WIDTH-2:0]         nav_q;
    logic [AW-1:0]                   cao_q;
    logic                            aerr_q;
    logic                            new_pixel_q;

    logic [3:0]                      slot_d;
    logic [WINDOW_WIDTH-1:0]         acc_mask_d;
    logic                            acc_err_d;
    logic [PW-1:0]                   cap_pix_d;

    // Slot k sits at offset (k/3-1, k%3-1); an out-of-range center has no valid slots.
    function automatic logic [WINDOW_WIDTH-1:0] in_image(input logic [AW-1:0] c);
        int row, col, r, cc;
        logic [WINDOW_WIDTH-1:0] m;
        m   = '0;
        row = int'(c) / N;
        col = int'(c) % N;
        if (int'(c) < M*N) begin
            for (int k = 0; k < WINDOW_WIDTH; k++) begin
                r    = row + k / 3 - 1;
                cc   = col + k % 3 - 1;
                m[k] = (r >= 0) && (r <= M-1) && (cc >= 0) && (cc <= N-1);
            end
        end
        return m;
    endfunction

    function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] c, input logic [3:0] k);
        int a;
        a = int'(c) + (int'(k) / 3 - 1) * N + int'(k) % 3 - 1;
        return AW'(a);
    endfunction

    always_comb begin
        slot_d     = slot_q + 4'd1;
        acc_mask_d = in_image(center_addr);
        acc_err_d  = (int'(center_addr) >= M*N);
        cap_pix_d  = pend_in_q ? mem_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            center_q    <= '0;
            err_q       <= 1'b0;
            mask_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            pend_in_q   <= 1'b0;
            win_q       <= '0;
            nav_q       <= '0;
            cao_q       <= '0;
            aerr_q      <= 1'b0;
            new_pixel_q <= 1'b0;
            for (int k = 0; k < WINDOW_WIDTH; k++) pix_q[k] <= '0;
        end else begin
            new_pixel_q <= 1'b0;
            rd_en_q     <= 1'b0;
            // Read issued this cycle returns next cycle; remember which slot it belongs to.
            pend_q      <= (state_q == FETCH);
            pend_slot_q <= slot_q;
            pend_in_q   <= rd_en_q;
            if (pend_q) pix_q[pend_slot_q] <= cap_pix_d;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q   <= FETCH;
                        center_q  <= center_addr;
                        err_q     <= acc_err_d;
                        mask_q    <= acc_mask_d;
                        slot_q    <= '0;
                        rd_en_q   <= acc_mask_d[0];
                        rd_addr_q <= slot_addr(center_addr, 4'd0);
                    end
                end
                FETCH: begin
                    if (slot_q == 4'd8) begin
                        state_q <= DRAIN;
                    end else begin
                        slot_q    <= slot_d;
                        rd_en_q   <= mask_q[slot_d];
                        rd_addr_q <= slot_addr(center_q, slot_d);
                    end
                end
                DRAIN: begin
                    // Slot 8 data arrives this cycle, so merge it straight into the output.
                    state_q     <= DONE;
                    new_pixel_q <= 1'b1;
                    for (int k = 0; k < WINDOW_WIDTH; k++)
                        win_q[k*PW +: PW] <= (pend_q && pend_slot_q == 4'(k)) ? cap_pix_d : pix_q[k];
                    nav_q  <= {mask_q[8:5], mask_q[3:0]};
                    cao_q  <= center_q;
                    aerr_q <= err_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset_n so ready is low while held in reset and high right after release.
    assign req_ready        = (state_q == IDLE) && reset_n;
    assign mem_rd_en        = rd_en_q;
    assign mem_rd_addr      = rd_addr_q;
    assign new_pixel        = new_pixel_q;
    assign window_values    = win_q;
    assign neigh_addr_valid = nav_q;
    assign center_addr_out  = cao_q;
    assign addr_err         = aerr_q;

endmodule

// File: tb/tb_eda_window_fetch.sv
// Directed bench for eda_window_fetch with a 16x16 image where pixel[a] = a[7:0].
module tb_eda_window_fetch;
    localparam int PW = 8;
    localparam int AW = 9;

    logic           clk = 1'b0;
    logic           reset_n, req_valid, req_ready, mem_rd_en, new_pixel, addr_err;
    logic [AW-1:0]  center_addr, mem_rd_addr, center_addr_out;
    logic [PW-1:0]  mem_rd_data;
    logic [71:0]    window_values;
    logic [7:0]     neigh_addr_valid;

    int             cyc = 0, np_cnt = 0, acc_cnt = 0;
    int             n_vec = 0, n_err = 0;
    logic [AW-1:0]  rd_log [$];
    logic [AW-1:0]  exp_q  [$];

    always #5 clk = ~clk;

    eda_window_fetch #(.M(16), .N(16), .PIXEL_WIDTH(8), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .center_addr(center_addr), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .new_pixel(new_pixel), .window_values(window_values),
        .neigh_addr_valid(neigh_addr_valid), .center_addr_out(center_addr_out), .addr_err(addr_err)
    );

    // Pixel memory: 1-cycle latency, junk when not reading.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_rd_addr[7:0] : 8'hEE;
        if (mem_rd_en) rd_log.push_back(mem_rd_addr);
        if (new_pixel) np_cnt <= np_cnt + 1;
        if (reset_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 72'(req_ready), 72'(0));
        check({tag, "_rd_en"}, 72'(mem_rd_en), 72'(0));
        check({tag, "_np"},    72'(new_pixel), 72'(0));
        check({tag, "_err"},   72'(addr_err), 72'(0));
        check({tag, "_win"},   window_values, 72'(0));
        check({tag, "_nav"},   72'(neigh_addr_valid), 72'(0));
        check({tag, "_cao"},   72'(center_addr_out), 72'(0));
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 40) begin @(negedge clk); k++; end
        check("req_ready", 72'(req_ready), 72'(1));
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1 with t_acc = cyc there.
    task automatic issue(input logic [AW-1:0] a, output int t_acc);
        req_valid   = 1'b1;
        center_addr = a;
        wait_ready();
        rd_log.delete();
        @(negedge clk);
        t_acc       = cyc;
        req_valid   = 1'b0;
        center_addr = 9'h0AA;
    endtask

    task automatic wait_np(output int t);
        int k = 0;
        while (!new_pixel && k < 40) begin @(negedge clk); k++; end
        check("np_seen", 72'(new_pixel), 72'(1));
        t = cyc;
    endtask

    task automatic check_reads();
        check("reads_n", 72'(rd_log.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
            check("read_addr", 72'(rd_log[i]), 72'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic fetch_case(input logic [AW-1:0] a, input logic [71:0] exp_win,
                              input logic [7:0] exp_nav, input logic exp_err);
        int ta, tn, acc0;
        acc0 = acc_cnt;
        issue(a, ta);
        // A request while busy must be dropped.
        @(negedge clk); @(negedge clk);
        req_valid = 1'b1; center_addr = 9'd5;
        @(negedge clk);
        req_valid = 1'b0;
        wait_np(tn);
        check("latency", 72'(tn - ta), 72'(10));
        check("window",  window_values, exp_win);
        check("nav",     72'(neigh_addr_valid), 72'(exp_nav));
        check("addr_err", 72'(addr_err), 72'(exp_err));
        check("cao",     72'(center_addr_out), 72'(a));
        check("accepts", 72'(acc_cnt - acc0), 72'(1));
        check_reads();
        @(negedge clk);
        check("np_pulse", 72'(new_pixel), 72'(0));
        check("win_hold", window_values, exp_win);
    endtask

    localparam logic [71:0] WIN17  = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    localparam logic [71:0] WIN0   = {8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [71:0] WIN255 = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'hEF, 8'hEE};
    localparam logic [71:0] WIN31  = {8'h00, 8'h2F, 8'h2E, 8'h00, 8'h1F, 8'h1E, 8'h00, 8'h0F, 8'h0E};

    initial begin
        int t1, t2, n1, n2, acc0, np0;
        reset_n = 1'b0; req_valid = 1'b0; center_addr = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);

        exp_q = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        fetch_case(9'd17, WIN17, 8'hFF, 1'b0);
        exp_q = '{0, 1, 16, 17};
        fetch_case(9'd0, WIN0, 8'hD0, 1'b0);
        exp_q = '{238, 239, 254, 255};
        fetch_case(9'd255, WIN255, 8'h0B, 1'b0);
        exp_q = '{14, 15, 30, 31, 46, 47};
        fetch_case(9'd31, WIN31, 8'h6B, 1'b0);
        fetch_case(9'd256, 72'(0), 8'h00, 1'b1);

        // Back-to-back with req_valid held high: 17 then 0.
        acc0 = acc_cnt;
        exp_q = '{0, 1, 2, 16, 17, 18, 32, 33, 34, 0, 1, 16, 17};
        req_valid = 1'b1; center_addr = 9'd17;
        wait_ready();
        rd_log.delete();
        @(negedge clk);
        t1 = cyc; center_addr = 9'd0;
        wait_np(n1);
        check("b2b_win1", window_values, WIN17);
        check("b2b_err1", 72'(addr_err), 72'(0));
        @(negedge clk);
        check("b2b_ready", 72'(req_ready), 72'(1));
        @(negedge clk);
        t2 = cyc; req_valid = 1'b0;
        wait_np(n2);
        check("b2b_accept_gap", 72'(t2 - t1), 72'(12));
        check("b2b_np2", 72'(n2 - t1), 72'(22));
        check("b2b_win2", window_values, WIN0);
        check("b2b_nav2", 72'(neigh_addr_valid), 72'(8'hD0));
        check("b2b_accepts", 72'(acc_cnt - acc0), 72'(2));
        check_reads();
        @(negedge clk);

        // Reset in cycle T+5 of a fetch aborts it.
        issue(9'd17, t1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        np0 = np_cnt;
        @(negedge clk);
        check_zero("abort");
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", 72'(req_ready), 72'(1));
        repeat (15) @(negedge clk);
        check("no_np_after_abort", 72'(np_cnt - np0), 72'(0));
        check("win_after_abort", window_values, 72'(0));

        exp_q = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        fetch_case(9'd17, WIN17, 8'hFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eda_window_fetch.md
EDA_WINDOW_FETCH -- requirements
Module: eda_window_fetch

Interface
REQ-001 The block SHALL have parameters M 16 (image rows), N 16 (image columns), PIXEL_WIDTH 8 (pixel bits), WINDOW_WIDTH 9 (pixels per 3x3 window), ADDR_WIDTH $clog2(M*N) (pixel address bits).
REQ-002 The block SHALL run on one clock and SHALL use a synchronous, active-low reset: clk, reset_n.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  center-address request.
- req_ready  out  1  block can accept a request.
- center_addr  in  ADDR_WIDTH  row-major address of the window center.
- mem_rd_en  out  1  pixel memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  pixel memory read address.
- mem_rd_data  in  PIXEL_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- new_pixel  out  1  one-cycle pulse: window outputs updated.
- window_values  out  PIXEL_WIDTH*WINDOW_WIDTH  slot k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH].
- neigh_addr_valid  out  WINDOW_WIDTH-1  in-image flags for the 8 neighbours.
- center_addr_out  out  ADDR_WIDTH  center address of the current window.
- addr_err  out  1  current window's center_addr was >= M*N.

Function
REQ-004 Slot k (0..8) SHALL be offset (dr,dc) = (k/3-1, k%3-1); slot 4 is the center.
REQ-005 neigh_addr_valid bit mapping SHALL be: slots 0-3 -> bits 0-3, slots 5-8 -> bits 4-7.
REQ-006 On acceptance, row = center_addr/N and col = center_addr%N SHALL be registered; slot k is in-image iff 0<=row+dr<=M-1 and 0<=col+dc<=N-1.
REQ-007 The slot-k address SHALL be center_addr + dr*N + dc, computed without wrap; it is only used for in-image slots.
REQ-008 The FSM SHALL have states IDLE, FETCH, DRAIN, DONE; req_ready=1 only in IDLE.
REQ-009 IDLE->FETCH SHALL occur when req_valid&req_ready (cycle T); center_addr is captured then.
REQ-010 FETCH SHALL last 9 cycles (T+1..T+9) with slot index 0..8, one slot per cycle, ascending.
REQ-011 In FETCH, mem_rd_en SHALL be 1 only for in-image slots, with mem_rd_addr set to the slot address; mem_rd_en SHALL be 0 in all other states.
REQ-012 Read data for slot k SHALL be captured at the end of cycle T+2+k; out-of-image slots SHALL be captured as 0.
REQ-013 FETCH->DRAIN SHALL occur after slot 8; DRAIN lasts 1 cycle (T+10); DRAIN->DONE.
REQ-014 In DONE (cycle T+11), new_pixel SHALL be 1 for exactly one cycle; window_values, neigh_addr_valid, center_addr_out and addr_err SHALL change only at this update and hold until the next one.
REQ-015 DONE->IDLE SHALL be unconditional; req_ready returns at T+12; request-to-request throughput is 12 cycles.
REQ-016 If center_addr >= M*N: all 9 slots are treated as out-of-image, no memory reads, window_values=0, neigh_addr_valid=0, addr_err=1 with new_pixel.
REQ-017 req_valid while req_ready=0 SHALL be ignored (not queued); center_addr changes after acceptance SHALL have no effect.
REQ-018 Single-row/column images (M=1 or N=1) SHALL be handled by the same in-image rule.

Reset
REQ-019 With reset_n=0 at a clk edge, the FSM SHALL go to IDLE and req_ready, mem_rd_en, new_pixel, addr_err, window_values, neigh_addr_valid, center_addr_out SHALL be 0.
REQ-020 A reset in the middle of a fetch SHALL abort it: no new_pixel, and read data returning the next cycle is discarded; req_ready=1 on the first cycle after reset_n returns to 1.

Verification (M=N=16, PIXEL_WIDTH=8, memory holds pixel[a]=a[7:0])
REQ-021 center_addr=17 -> reads 0,1,2,16,17,18,32,33,34 in order; window_values slot k = those values; neigh_addr_valid=8'hFF; new_pixel at T+11.
REQ-022 center_addr=0 -> reads only 0,1,16,17; neigh_addr_valid=8'hD0; slots 0,1,2,3,6 = 0.
REQ-023 center_addr=255 -> reads 238,239,254,255; neigh_addr_valid=8'h0B; center_addr=31 -> neigh_addr_valid=8'h6B, no reads of 16 or 48.
REQ-024 center_addr=256 (requires ADDR_WIDTH widened to 9 in the bench) -> zero mem_rd_en pulses, window_values=0, neigh_addr_valid=0, addr_err=1 with new_pixel.
REQ-025 Back-to-back: req_valid held high with addresses 17 then 0 -> second accept at T+12, second new_pixel at T+23; req_valid pulses during busy are ignored.
REQ-026 reset_n=0 at T+5 of a fetch -> all outputs 0 next cycle, no new_pixel; a new request accepted right after reset completes normally.
